// File: rtl/clock_ratio_monitor.sv
// Measures period and high time of a divided clock sampled in the reference domain,
// declares lock after LOCK_COUNT consecutive correct periods and counts violations.
module clock_ratio_monitor #(
    parameter int DIVIDE_LOG2 = 2,
    parameter int CNT_W       = 8,
    parameter int LOCK_COUNT  = 4,
    parameter int ERR_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_clk_in,
    input  logic             io_enable,
    output logic [CNT_W-1:0] io_period,
    output logic [CNT_W-1:0] io_high_cycles,
    output logic             io_period_valid,
    output logic             io_locked,
    output logic             io_error,
    output logic [ERR_W-1:0] io_error_count
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] EXP_PER   = CNT_W'(1 << DIVIDE_LOG2);
    localparam logic [CNT_W-1:0] EXP_HI    = CNT_W'(1 << (DIVIDE_LOG2 - 1));
    localparam logic [3:0]       LOCK_LAST = 4'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOCKED} state_t;

    state_t           state;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [3:0]       good_cnt;
    logic             rise;
    logic             good;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + ERR_W'(1);
    endfunction

    // The divided clock is generated from `clock`, so two plain flops suffice for edge detection.
    assign rise = s1 & ~s2;
    assign good = (per_cnt == EXP_PER) && (hi_cnt == EXP_HI);

    always_ff @(posedge clock) begin
        if (reset) begin
            s1              <= 1'b0;
            s2              <= 1'b0;
            state           <= IDLE;
            good_cnt        <= '0;
            io_period       <= '0;
            io_high_cycles  <= '0;
            io_period_valid <= 1'b0;
            io_locked       <= 1'b0;
            io_error        <= 1'b0;
            io_error_count  <= '0;
        end else begin
            s1              <= io_clk_in;
            s2              <= s1;
            io_period_valid <= 1'b0;
            io_error        <= 1'b0;
            if (!io_enable) begin
                // Partial measurement is dropped silently; the error count is held.
                state     <= IDLE;
                per_cnt   <= '0;
                hi_cnt    <= '0;
                good_cnt  <= '0;
                io_locked <= 1'b0;
            end else begin
                if (state == IDLE) begin
                    per_cnt <= '0;
                    hi_cnt  <= '0;
                end else if (rise) begin
                    per_cnt <= CNT_W'(1);
                    hi_cnt  <= {{(CNT_W-1){1'b0}}, s1};
                end else begin
                    per_cnt <= sat_inc_cnt(per_cnt);
                    if (s1) hi_cnt <= sat_inc_cnt(hi_cnt);
                end

                case (state)
                    IDLE: state <= ARM;
                    ARM:  if (rise) state <= MEASURE;
                    MEASURE, LOCKED: begin
                        // A rise outranks saturation, so a coincident pair counts one error.
                        if (rise) begin
                            io_period       <= per_cnt;
                            io_high_cycles  <= hi_cnt;
                            io_period_valid <= 1'b1;
                            if (good) begin
                                if (state == MEASURE) begin
                                    good_cnt <= good_cnt + 4'd1;
                                    if (good_cnt == LOCK_LAST) begin
                                        state     <= LOCKED;
                                        io_locked <= 1'b1;
                                    end
                                end
                            end else begin
                                io_error       <= 1'b1;
                                io_error_count <= sat_inc_err(io_error_count);
                                good_cnt       <= '0;
                                state          <= MEASURE;
                                io_locked      <= 1'b0;
                            end
                        end else if (per_cnt == CNT_MAX) begin
                            io_error       <= 1'b1;
                            io_error_count <= sat_inc_err(io_error_count);
                            good_cnt       <= '0;
                            state          <= ARM;
                            io_locked      <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/clock_ratio_monitor.md
# clock_ratio_monitor

Testbench checker that sits directly downstream of the power-of-two clock divider. It samples the divided clock as data in the undivided `clock` domain, measures the period and high time of every divided cycle, and declares lock once the measured ratio matches the expected power of two. It flags every period, duty or stuck-clock violation so the bench can fail on a broken divider chain.

## Interface
- `DIVIDE_LOG2`, default 2: expected division ratio is `1 << DIVIDE_LOG2`; legal range 1..(CNT_W-1).
- `CNT_W`, default 8: width of the period and high-time counters.
- `LOCK_COUNT`, default 4: consecutive good periods required for lock; legal range 1..15.
- `ERR_W`, default 16: width of the error counter.

- `clock`  in  1  undivided reference clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_clk_in`  in  1  divided clock under test, sampled as data.
- `io_enable`  in  1  monitor enable.
- `io_period`  out  CNT_W  last measured period, in `clock` cycles.
- `io_high_cycles`  out  CNT_W  last measured high time, in `clock` cycles.
- `io_period_valid`  out  1  one-cycle pulse when `io_period` and `io_high_cycles` update.
- `io_locked`  out  1  the expected ratio has held for `LOCK_COUNT` consecutive periods.
- `io_error`  out  1  one-cycle pulse per detected violation.
- `io_error_count`  out  ERR_W  saturating count of violations.

## Operation
- Sampling: `s1 <= io_clk_in`, `s2 <= s1`. `rise = s1 & ~s2`. No synchronizer, because the input is derived from `clock`.
- Counters:
  - `per_cnt` and `hi_cnt` saturate at `2^CNT_W-1`.
  - On `rise`: `per_cnt <= 1`, and `hi_cnt <= 1` if `s1` else 0.
  - Otherwise: `per_cnt` increments, and `hi_cnt` increments while `s1`=1.
- States:
  - IDLE: entered on `io_enable`=0. Counters are cleared and `io_locked`=0. Goes to ARM when `io_enable`=1.
  - ARM: waits for the first `rise`, then goes to MEASURE. This first rise produces no measurement.
  - MEASURE: on each `rise`, register `io_period <= per_cnt` and `io_high_cycles <= hi_cnt` and pulse `io_period_valid`. The period is good iff `per_cnt == 1<<DIVIDE_LOG2` and `hi_cnt == 1<<(DIVIDE_LOG2-1)`.
    - Good period: `good_cnt` increments. When it reaches `LOCK_COUNT`, go to LOCKED.
    - Bad period: pulse `io_error`, clear `good_cnt`, and stay in MEASURE.
  - LOCKED: measures the same way as MEASURE, with `io_locked`=1. A bad period pulses `io_error`, clears `good_cnt` and returns to MEASURE.
- Stuck clock: in MEASURE or LOCKED, when `per_cnt` reaches saturation, pulse `io_error` once, clear `good_cnt` and go to ARM.
- `io_error_count` increments on each `io_error` pulse and saturates at `2^ERR_W-1`. It is cleared only by `reset`; `io_enable`=0 holds it.
- Simultaneous events: if a `rise` coincides with saturation, the rise takes priority and produces a bad-period error. Only one error is counted that cycle.
- `io_enable` deasserted mid-period: go to IDLE next cycle. The partial measurement is discarded and no error is raised.

## Timing
- Reset values: `io_period`=0, `io_high_cycles`=0, `io_period_valid`=0, `io_locked`=0, `io_error`=0, `io_error_count`=0. Internally, `s1`=`s2`=0, the state is IDLE and `good_cnt`=0.
- `reset` asserted mid-operation takes effect at the next edge and overrides `io_enable`.
- Latency:
  - `io_clk_in` goes high before edge N, so `s1`=1 after edge N.
  - `rise` is true during cycle N→N+1.
  - `io_period_valid`, `io_period` and `io_high_cycles` update at edge N+1.
  - `io_error` for a bad period also pulses at edge N+1.
  - `io_locked` rises at the same edge as the `io_period_valid` that completes the `LOCK_COUNT`th good period.
- Steady state: `io_period_valid` pulses every `1<<DIVIDE_LOG2` cycles.
- Stuck-clock error: `io_error` pulses at the edge after `per_cnt` reaches `2^CNT_W-1`.

## Test plan
- **Clean divide-by-4** (defaults; `io_clk_in` 2 cycles high, 2 low; `io_enable`=1):
  - After the arming rise plus 4 rises, `io_locked`=1.
  - `io_period`=4, `io_high_cycles`=2.
  - `io_period_valid` pulses every 4 cycles and `io_error_count` stays 0.
- **Period glitch** (after lock, one period of 5 cycles: 3 high, 2 low):
  - A single `io_error` pulse; `io_error_count`=1; `io_locked`=0 at the same edge.
  - Relock after 4 further good periods.
- **Duty error** (period 4 with 3 high, 1 low):
  - `io_period`=4, `io_high_cycles`=3, and `io_error` every period.
  - `io_locked` never asserts.
- **Stuck low** (after lock, hold `io_clk_in`=0):
  - Exactly one `io_error` at edge (rise + 256); `io_error_count`=1; `io_locked`=0.
  - No further errors until clocking resumes.
  - After resuming: one arming rise, then relock after 4 good periods.
- **Enable drop** (deassert `io_enable` for 3 cycles mid-period, then reassert):
  - No `io_error`; `io_locked`=0 while in IDLE; `io_error_count` is held.
  - Relock after the arming rise plus 4 good periods.
- **Reset mid-operation** (assert `reset` for 1 cycle while locked with `io_error_count`=2):
  - At the next edge all outputs are 0.
  - Monitoring resumes from ARM once `io_enable`=1 and `reset`=0.
